noc_flit_sink: RTL and testbench
================================

NOC_FLIT_SINK -- requirements
Module: noc_flit_sink

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 32: flit payload width.
REQ-002 SHALL have parameter DEST_WIDTH, default 4: destination field width ({tid, tdest}).
REQ-003 SHALL have parameter FLIT_BUFFER_DEPTH, default 8: receive FIFO entries; power of 2, at least 2.
REQ-004 SHALL have parameter CNT_WIDTH, default 16: packet counter width.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; the ports are named clk and rst_n.
REQ-006 Ports:
- clk, input, 1: NoC clock; all logic on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- data_in, input, FLIT_WIDTH: flit payload from the router output port.
- dest_in, input, DEST_WIDTH: flit destination.
- is_tail_in, input, 1: flit is the last flit of its packet.
- send_in, input, 1: flit valid this cycle.
- credit_out, input/output direction output, 1: one-cycle credit return pulse to the router.
- axis_out_tvalid, output, 1: AXI-stream valid.
- axis_out_tready, input, 1: AXI-stream ready.
- axis_out_tdata, output, FLIT_WIDTH: head-flit payload.
- axis_out_tlast, output, 1: head-flit tail bit.
- axis_out_tdest, output, DEST_WIDTH: head-flit destination.
- occupancy, output, $clog2(FLIT_BUFFER_DEPTH)+1: number of FIFO entries.
- pkt_count, output, CNT_WIDTH: count of tail flits delivered.
- overflow_err, output, 1: sticky flag; a flit arrived while the FIFO was full.
- framing_err, output, 1: sticky flag; dest_in changed inside a packet.
- err_clear, input, 1: synchronous clear of both sticky flags.

Function
REQ-007 Flow control SHALL be credit based: the sender starts with FLIT_BUFFER_DEPTH credits, and each credit_out pulse returns exactly one credit.
REQ-008 Push: when send_in=1 and the FIFO is not full, the block SHALL write {data_in, dest_in, is_tail_in} at that clock edge.
REQ-009 The FIFO SHALL be first-word fall-through: a flit pushed at edge N SHALL appear on axis_out_* with tvalid=1 after edge N, with no added bubble.
REQ-010 axis_out_tvalid SHALL equal (occupancy != 0), and the axis_out_* data SHALL reflect the FIFO head.
REQ-011 Pop: a pop SHALL occur when tvalid and tready are both 1 at a clock edge.
REQ-012 axis_out_tdata/tlast/tdest SHALL remain stable while tvalid=1 and tready=0.
REQ-013 The block SHALL register credit_out as a one-cycle pulse in the cycle after each pop, giving exactly one pulse per popped flit.
REQ-014 Simultaneous push and pop with the FIFO non-full SHALL perform both operations, leaving occupancy unchanged.
REQ-015 Simultaneous push and pop with the FIFO full SHALL be treated as overflow: the incoming flit is dropped, overflow_err is set, and the pop proceeds.
REQ-016 Push with the FIFO full SHALL drop the flit, set overflow_err, issue no credit for it, and leave occupancy unchanged.
REQ-017 Read and write pointers SHALL be $clog2(FLIT_BUFFER_DEPTH) bits wide and wrap modulo FLIT_BUFFER_DEPTH.
REQ-018 Occupancy SHALL saturate neither below 0 nor above FLIT_BUFFER_DEPTH.
REQ-019 The framing FSM SHALL have states IDLE and IN_PKT, and SHALL observe only accepted pushes.
REQ-020 In IDLE, an accepted flit with is_tail_in=0 SHALL latch dest_in and move to IN_PKT; an accepted flit with is_tail_in=1 SHALL stay in IDLE.
REQ-021 In IN_PKT, an accepted flit with dest_in not equal to the latched dest SHALL set framing_err; the flit is still stored.
REQ-022 In IN_PKT, an accepted flit with is_tail_in=1 SHALL return the FSM to IDLE.
REQ-023 pkt_count SHALL increment on each pop with tlast=1, and wrap from all-ones to 0.
REQ-024 err_clear=1 SHALL clear both sticky flags at the next edge; if a new error occurs in the same cycle, setting SHALL win.

Reset
REQ-025 rst_n=0 SHALL immediately force the following values:
- FIFO pointers and occupancy: 0.
- axis_out_tvalid: 0.
- credit_out: 0.
- pkt_count: 0.
- overflow_err, framing_err: 0.
- FSM: IDLE.
REQ-026 FIFO storage contents need not be reset; axis_out_tdata, tlast and tdest are don't-care while tvalid=0.
REQ-027 Reset mid-packet SHALL discard all buffered flits and SHALL emit no credit pulses for them; the sender is reset together with this block.
REQ-028 After rst_n deasserts, the first push SHALL be accepted at the next rising edge.

Verification
REQ-029 Single flit: send one flit with data 0xDEADBEEF, dest 0x5, tail 1, and hold tready=1. Required: tvalid=1 the cycle after the push with matching fields; credit_out pulses once the cycle after the pop; pkt_count=1.
REQ-030 Fill and backpressure: hold tready=0 and push 8 flits. Required: occupancy=8, no credit pulses, overflow_err=0. Then raise tready. Required: flits drain in order, 8 credit pulses, occupancy=0.
REQ-031 Overflow: with the FIFO full, push a 9th flit 0x11111111. Required: overflow_err=1, occupancy=8, and the dropped flit never appears on the output. Then assert err_clear. Required: overflow_err=0.
REQ-032 Framing: push a non-tail flit with dest 0x3, then a tail flit with dest 0x4. Required: framing_err=1 and both flits delivered. Then push a single-flit packet. Required: no new error.
REQ-033 Wrap: stream 20 flits with tready=1 and send_in every cycle. Required: occupancy never exceeds 1, data order is preserved across pointer wrap, and there are 20 credit pulses.
REQ-034 Reset mid-operation: assert rst_n=0 with 5 flits buffered. Required: tvalid=0, occupancy=0 and pkt_count=0 immediately, and no credit pulses during or after reset.

Source files
------------

// File: rtl/noc_flit_sink.sv
// noc_flit_sink: NoC ejection port. Buffers incoming flits in a first-word
// fall-through FIFO, presents the head on an AXI-stream master, returns one
// credit per popped flit, counts delivered packets and flags overflow and
// mid-packet destination changes.
module noc_flit_sink #(
  parameter int FLIT_WIDTH        = 32,
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_BUFFER_DEPTH = 8,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [FLIT_WIDTH-1:0]              data_in,
  input  logic [DEST_WIDTH-1:0]              dest_in,
  input  logic                               is_tail_in,
  input  logic                               send_in,
  output logic                               credit_out,
  output logic                               axis_out_tvalid,
  input  logic                               axis_out_tready,
  output logic [FLIT_WIDTH-1:0]              axis_out_tdata,
  output logic                               axis_out_tlast,
  output logic [DEST_WIDTH-1:0]              axis_out_tdest,
  output logic [$clog2(FLIT_BUFFER_DEPTH):0] occupancy,
  output logic [CNT_WIDTH-1:0]               pkt_count,
  output logic                               overflow_err,
  output logic                               framing_err,
  input  logic                               err_clear
);
  localparam int AW = $clog2(FLIT_BUFFER_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FLIT_BUFFER_DEPTH);

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  tail;
  } flit_t;

  typedef enum logic {IDLE, IN_PKT} fsm_t;

  flit_t                 r_mem [FLIT_BUFFER_DEPTH];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [AW:0]           r_count;
  logic                  r_credit;
  logic [CNT_WIDTH-1:0]  r_pkt;
  logic                  r_ovf;
  logic                  r_frm;
  fsm_t                  r_state;
  logic [DEST_WIDTH-1:0] r_dest;

  logic  w_full, w_valid, w_push, w_pop, w_ovf_set, w_frm_set;
  flit_t w_head;

  // Full FIFO drops the incoming flit even if a pop happens on the same edge,
  // so acceptance never depends on the sink side.
  assign w_full    = (r_count == DEPTH_C);
  assign w_valid   = (r_count != '0);
  assign w_push    = send_in & ~w_full;
  assign w_pop     = w_valid & axis_out_tready;
  assign w_ovf_set = send_in & w_full;
  assign w_frm_set = w_push & (r_state == IN_PKT) & (dest_in != r_dest);
  assign w_head    = r_mem[r_rptr];

  // Storage write; contents are don't-care until a pointer covers them.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {data_in, dest_in, is_tail_in};
  end

  // Pointers and occupancy; pointers wrap naturally at power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Credit pulse one cycle after each pop; delivered-packet counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit <= 1'b0;
      r_pkt    <= '0;
    end else begin
      r_credit <= w_pop;
      if (w_pop && w_head.tail) r_pkt <= r_pkt + 1'b1;
    end
  end

  // Sticky overflow flag; a new error wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
    else if (err_clear) r_ovf <= 1'b0;
  end

  // Framing FSM over accepted pushes; owns the sticky framing flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_dest  <= '0;
      r_frm   <= 1'b0;
    end else begin
      if (w_frm_set)      r_frm <= 1'b1;
      else if (err_clear) r_frm <= 1'b0;
      if (w_push) begin
        case (r_state)
          IDLE: if (!is_tail_in) begin
            r_state <= IN_PKT;
            r_dest  <= dest_in;
          end
          IN_PKT: if (is_tail_in) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign credit_out      = r_credit;
  assign axis_out_tvalid = w_valid;
  assign axis_out_tdata  = w_head.data;
  assign axis_out_tlast  = w_head.tail;
  assign axis_out_tdest  = w_head.dest;
  assign occupancy       = r_count;
  assign pkt_count       = r_pkt;
  assign overflow_err    = r_ovf;
  assign framing_err     = r_frm;
endmodule

// File: tb/tb_noc_flit_sink.sv
// tb_noc_flit_sink: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the sink.
module tb_noc_flit_sink;
  localparam int FW = 32, DW = 4, D = 8, CW = 4;

  logic          clk = 0, rst_n = 0;
  logic [FW-1:0] din = '0;
  logic [DW-1:0] dst = '0;
  logic          tl = 0, send = 0, tready = 0, eclr = 0;
  logic          credit_out, tvalid, tlast, ovf, frm;
  logic [FW-1:0] tdata;
  logic [DW-1:0] tdest;
  logic [3:0]    occ;
  logic [CW-1:0] pkt;

  noc_flit_sink #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(D),
                  .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(din), .dest_in(dst), .is_tail_in(tl),
    .send_in(send), .credit_out(credit_out), .axis_out_tvalid(tvalid),
    .axis_out_tready(tready), .axis_out_tdata(tdata), .axis_out_tlast(tlast),
    .axis_out_tdest(tdest), .occupancy(occ), .pkt_count(pkt),
    .overflow_err(ovf), .framing_err(frm), .err_clear(eclr));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered flits plus the spec's flags.
  typedef struct { logic [FW-1:0] d; logic [DW-1:0] t; logic l; } mflit_t;
  mflit_t        q[$];
  logic          m_cred = 0, m_ovf = 0, m_frm = 0, m_inpkt = 0;
  logic [CW-1:0] m_pkt = '0;
  logic [DW-1:0] m_pdest = '0;
  bit            m_pop, m_full, m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_cred = 0; m_pkt = '0; m_ovf = 0; m_frm = 0; m_inpkt = 0;
    end else begin
      m_pop  = (q.size() != 0) && tready;
      m_full = (q.size() == D);
      m_acc  = send && !m_full;
      m_cred = m_pop;
      if (eclr) begin m_ovf = 0; m_frm = 0; end
      if (send && m_full) m_ovf = 1;
      if (m_pop) begin
        if (q[0].l) m_pkt = m_pkt + 1'b1;
        void'(q.pop_front());
      end
      if (m_acc) begin
        q.push_back('{d: din, t: dst, l: tl});
        if (m_inpkt) begin
          if (dst != m_pdest) m_frm = 1;
          if (tl) m_inpkt = 0;
        end else if (!tl) begin
          m_inpkt = 1; m_pdest = dst;
        end
      end
    end
  end

  // Per-cycle compare plus a few monitors used by directed checks.
  int cred_cnt = 0, max_occ = 0;
  bit seen_drop = 0;
  always @(negedge clk) begin
    if (credit_out) cred_cnt++;
    if (rst_n) begin
      chk("tvalid", tvalid, q.size() != 0);
      chk("occupancy", occ, q.size());
      chk("credit_out", credit_out, m_cred);
      chk("pkt_count", pkt, m_pkt);
      chk("overflow_err", ovf, m_ovf);
      chk("framing_err", frm, m_frm);
      if (q.size() != 0) begin
        chk("tdata", tdata, q[0].d);
        chk("tdest", tdest, q[0].t);
        chk("tlast", tlast, q[0].l);
      end
      if (tvalid && tdata == 32'h1111_1111) seen_drop = 1;
      if (int'(occ) > max_occ) max_occ = int'(occ);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push1(logic [FW-1:0] d, logic [DW-1:0] t, logic l);
    @(negedge clk); send = 1; din = d; dst = t; tl = l;
    @(negedge clk); send = 0;
  endtask

  task automatic drain(string nm);
    int k;
    tready = 1;
    for (k = 0; k < 100 && occ != 0; k++) @(negedge clk);
    if (occ != 0) chk({nm, "_drain_timeout"}, occ, 0);
    cyc(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  int c0;
  initial begin
    // Reset state
    #12;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_occ", occ, 0);
    chk("rst_credit", credit_out, 0);
    chk("rst_pkt", pkt, 0);
    chk("rst_flags", {ovf, frm}, 0);
    @(negedge clk); rst_n = 1;

    // Single flit
    tready = 1;
    push1(32'hDEAD_BEEF, 4'h5, 1);
    chk("sf_tvalid", tvalid, 1);
    chk("sf_tdata", tdata, 32'hDEAD_BEEF);
    chk("sf_tdest", tdest, 4'h5);
    chk("sf_tlast", tlast, 1);
    cyc(1);
    chk("sf_credit", credit_out, 1);
    chk("sf_pkt", pkt, 1);
    chk("sf_empty", tvalid, 0);
    cyc(1);
    chk("sf_credit_once", credit_out, 0);

    // Fill with backpressure
    tready = 0; c0 = cred_cnt;
    for (int i = 0; i < D; i++) begin
      @(negedge clk); send = 1; din = 32'hA000_0000 + i; dst = 4'(i); tl = 1;
    end
    @(negedge clk); send = 0;
    chk("fill_occ", occ, 8);
    chk("fill_ovf", ovf, 0);
    chk("fill_no_credit", cred_cnt - c0, 0);

    // Overflow and clear
    push1(32'h1111_1111, 4'h9, 1);
    chk("ovf_set", ovf, 1);
    chk("ovf_occ", occ, 8);
    eclr = 1; cyc(1); eclr = 0;
    chk("ovf_clear", ovf, 0);
    drain("fill");
    chk("fill_credits", cred_cnt - c0, 8);
    chk("drop_absent", seen_drop, 0);
    chk("fill_pkt", pkt, 9);

    // Framing error, then a clean single-flit packet
    push1(32'h0000_0033, 4'h3, 0);
    push1(32'h0000_0044, 4'h4, 1);
    chk("frm_set", frm, 1);
    eclr = 1; cyc(1); eclr = 0;
    chk("frm_clear", frm, 0);
    push1(32'h0000_0055, 4'h7, 1);
    cyc(2);
    chk("frm_clean", frm, 0);
    drain("frm");

    // Streaming across pointer wrap
    c0 = cred_cnt; max_occ = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); send = 1; din = 32'hC000_0000 + i; dst = 4'h2; tl = 1;
    end
    @(negedge clk); send = 0;
    cyc(3);
    chk("wrap_max_occ", max_occ, 1);
    chk("wrap_credits", cred_cnt - c0, 20);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      send   = ($urandom_range(0, 3) != 0);
      tready = ($urandom_range(0, 2) != 0);
      din    = $urandom;
      dst    = 4'($urandom_range(0, 2));
      tl     = ($urandom_range(0, 2) == 0);
      eclr   = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk); send = 0; eclr = 0;
    drain("rand");

    // Reset with flits buffered
    tready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); send = 1; din = 32'hE000_0000 + i; dst = 4'h1; tl = 1;
    end
    @(negedge clk); send = 0;
    chk("mid_occ_pre", occ, 5);
    @(posedge clk); #2 rst_n = 0; tready = 1;
    #1;
    chk("mid_tvalid", tvalid, 0);
    chk("mid_occ", occ, 0);
    chk("mid_pkt", pkt, 0);
    chk("mid_credit", credit_out, 0);
    c0 = cred_cnt;
    cyc(4);
    @(posedge clk); #2 rst_n = 1;
    cyc(3);
    chk("mid_no_credit", cred_cnt - c0, 0);
    push1(32'h0BAD_F00D, 4'h6, 1);
    chk("post_rst_push", tvalid, 1);
    chk("post_rst_data", tdata, 32'h0BAD_F00D);
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
